// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
// One transfer per cycle in which imem_req and imem_ready are both high; rdata is combinational that cycle.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// IF stage owning the PC: a zero-wait memory gives 1 cycle to first Effective_out, then 1 instr/cycle.
// Enable holds the presented instruction and suppresses prefetch, Redirect squashes it; IF_PERF_CNT_EN adds perf counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Enable,
  input  logic                   Redirect,
  input  logic [31:0]            Redirect_PC,
  if_fetch_stage_if.master       imem,
  output logic                   Effective_out,
  output logic [31:0]            PC_out,
  output logic [31:0]            IR_out
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]            fetch_cnt,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            squash_cnt
`endif
);

  typedef enum logic {FETCH = 1'b0, VALID = 1'b1} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_buf;
  logic [31:0] ir_buf;
  logic [31:0] redirect_tgt;
  logic        take;

  assign redirect_tgt = Redirect_PC & ~32'd3;

  // In VALID, a new request is only issued once the presented instruction is consumed.
  assign imem.imem_req  = (state == FETCH) ? 1'b1 : (~Enable & ~Redirect);
  assign imem.imem_addr = pc;

  // A transfer that coincides with a redirect is dropped.
  assign take = imem.imem_req & imem.imem_ready & ~Redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      pc_buf <= '0;
      ir_buf <= '0;
    end else if (Redirect) begin
      state <= FETCH;
      pc    <= redirect_tgt;
    end else if (take) begin
      state  <= VALID;
      ir_buf <= imem.imem_rdata;
      pc_buf <= pc;
      pc     <= pc + PC_STEP;
    end else if (state == VALID && !Enable) begin
      state <= FETCH;
    end
  end

  assign Effective_out = (state == VALID);
  assign PC_out        = (state == VALID) ? pc_buf : '0;
  assign IR_out        = (state == VALID) ? ir_buf : '0;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt  <= '0;
      stall_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      if (take)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (state == VALID && Enable && !Redirect)
        stall_cnt <= stall_cnt + 32'd1;
      if (Redirect && (state == VALID || imem.imem_ready))
        squash_cnt <= squash_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage; the producer side of the IF/ID pipeline register.
- Owns the PC and issues requests to the instruction memory.
- Presents {PC, IR, Effective} to IF/ID and obeys the stall (Enable) and branch-redirect signals from the hazard and branch logic.
- A fetched instruction is held stable while stalled. A redirect squashes it, so IF/ID never captures a stale or duplicated instruction.

Parameters:
- RESET_PC, 32'h0000_3000: PC loaded on reset; the first fetch address.
- PC_STEP, 4: sequential PC increment in bytes.

Ports:
- clk  input  1  clock, all state on posedge.
- rst  input  1  synchronous, active-high reset.
- Enable  input  1  stall from hazard unit; 1 = hold (same polarity as IF/ID Enable).
- Redirect  input  1  branch/jump taken; load Redirect_PC.
- Redirect_PC  input  32  redirect target; bits [1:0] ignored, forced 00.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address (word aligned).
- imem_ready  input  1  memory returns data this cycle; transfer occurs when imem_req&imem_ready.
- imem_rdata  input  32  instruction word, valid when imem_ready.
- Effective_out  output  1  PC_out/IR_out hold a valid instruction; to IF/ID Effective_in.
- PC_out  output  32  PC of presented instruction; to IF/ID PC_in.
- IR_out  output  32  presented instruction; to IF/ID IR_in.

Behaviour:
- State: pc (next fetch address), pc_buf, ir_buf, FSM {FETCH, VALID}.
- Reset (rst=1 at posedge, overrides all):
  - pc=RESET_PC, state=FETCH.
  - pc_buf=0, ir_buf=0, so Effective_out=0, PC_out=0, IR_out=0.
- Outputs:
  - Effective_out = (state==VALID).
  - PC_out = pc_buf and IR_out = ir_buf when VALID; both forced 0 otherwise (bubble = nop).
- Memory protocol:
  - Transfer only in a cycle with imem_req=1 and imem_ready=1; data is combinational that cycle.
  - imem_req may drop in any cycle with no side effects.
  - imem_addr = pc whenever imem_req=1.
- FETCH:
  - imem_req=1.
  - If Redirect: pc<=Redirect_PC&~3, stay FETCH; any returned data is discarded.
  - Else if imem_ready: ir_buf<=imem_rdata, pc_buf<=pc, pc<=pc+PC_STEP, go to VALID.
  - Else stay (wait states, unbounded).
  - Enable is ignored in FETCH; nothing is presented.
- VALID:
  - imem_req = ~Enable & ~Redirect (prefetch of the next instruction only when the current one is consumed).
  - Redirect (priority over Enable): pc<=Redirect_PC&~3, go to FETCH. The presented instruction is squashed; IF/ID is flushed by the hazard unit the same cycle.
  - Enable=1: hold pc, pc_buf, ir_buf unchanged, stay VALID.
  - Enable=0 & imem_ready: consume current; load new ir_buf/pc_buf; pc+=PC_STEP; stay VALID (1 instr/cycle throughput).
  - Enable=0 & ~imem_ready: consume current, go to FETCH.
- Latency: with a zero-wait-state memory, reset deassert to first Effective_out=1 is 1 cycle, then 1 instruction per cycle. Each memory wait state adds 1 cycle.
- Arithmetic:
  - pc+PC_STEP is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
  - Redirect_PC[1:0] are always cleared.
- Simultaneous events:
  - Redirect+Enable: redirect wins.
  - Redirect+imem_ready: data dropped, no pc increment.
  - rst beats everything.
- Reset mid-wait: an outstanding request is abandoned; the next fetch is RESET_PC.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt[31:0], stall_cnt[31:0] and squash_cnt[31:0], all reset to 0 and wrapping.
  - fetch_cnt increments on each accepted transfer that is kept.
  - stall_cnt increments each cycle in VALID with Enable=1 and Redirect=0.
  - squash_cnt increments on each Redirect while VALID, or while FETCH with imem_ready=1.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Zero-wait memory (ready=1, rdata=addr^32'hA5A5_0000), Enable=0 after reset: PC_out sequence 3000,3004,3008 on consecutive cycles; Effective_out 0 then 1 from cycle 1.
- Enable=1 for 3 cycles while VALID at PC 3004: PC_out=3004 and IR_out held 3 cycles, imem_req=0; resumes with 3008 with no skip or duplicate.
- Redirect=1, Redirect_PC=32'h0000_4003 while VALID at 3008: next fetch addr=4000, Effective_out=0 one cycle, then PC_out=4000; 300C is never presented.
- Memory with 2 wait states: each instruction is VALID for at most 1 consumed cycle; Effective_out gaps of 2 cycles; data only latched when ready=1.
- Redirect and imem_ready together in FETCH: data discarded, imem_addr=target the next cycle; also Redirect with Enable=1 redirects.
- rst asserted mid-wait and pc set to 32'hFFFF_FFFC via redirect: reset returns Effective_out=0 and the next fetch is 3000; without reset, the PC after FFFF_FFFC is 0000_0000.
